// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, partial-product
// selects and the Booth digit decoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PP_ZERO = 3'd0,
        PP_POS1 = 3'd1,
        PP_POS2 = 3'd2,
        PP_NEG1 = 3'd3,
        PP_NEG2 = 3'd4
    } pp_sel_t;

    // Map a multiplier bit triple {b[i+1], b[i], b[i-1]} to a Booth digit
    function automatic pp_sel_t booth_decode(input logic [2:0] t);
        pp_sel_t sel;
        sel = PP_ZERO;
        case (t)
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit carry-lookahead adder: every carry is formed directly from the
// generate/propagate terms below it and the carry-in.
module carry_lookahead_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    always_comb begin
        logic v_c;
        logic v_run;
        v_c    = 1'b0;
        v_run  = 1'b0;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < int'(N); i++) begin
            v_c   = w_g[i];
            v_run = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                v_c   = v_c | (w_g[j] & v_run);
                v_run = v_run & w_p[j];
            end
            w_c[i+1] = v_c | (i_cin & v_run);
        end
    end

    assign o_sum  = w_p ^ w_c[N-1:0];
    assign o_cout = w_c[N];

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Iterative radix-4 Booth multiplier, signed or unsigned operands, two
// multiplier bits retired per clock, valid/ready on both sides.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           is_signed,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int unsigned ITER = N / 2 + 1;
    localparam int unsigned W    = N + 2;
    localparam int unsigned PW   = 2 * N;
    localparam int unsigned CW   = $clog2(ITER + 1);

    if ((N % 2) != 0 || N < 4) begin : g_param_check
        $error("booth_radix4_multiplier: N must be even and at least 4");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_acc;
    logic [W:0]      r_bx;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_product;
    logic            r_out_valid;
    logic            r_busy;

    logic [W-1:0]    w_pp;
    logic            w_cin;
    logic [W-1:0]    w_sum;
    logic            w_unused_cout;
    logic [2*W:0]    w_shifted;
    logic            w_accept;
    logic            w_last;
    logic            w_ext_a;
    logic            w_ext_b;

    // Digit select: negation is invert here plus carry-in on the adder
    always_comb begin
        w_pp  = '0;
        w_cin = 1'b0;
        case (booth_decode(r_bx[2:0]))
            PP_POS1: w_pp = r_a;
            PP_POS2: w_pp = {r_a[W-2:0], 1'b0};
            PP_NEG1: begin
                w_pp  = ~r_a;
                w_cin = 1'b1;
            end
            PP_NEG2: begin
                w_pp  = ~{r_a[W-2:0], 1'b0};
                w_cin = 1'b1;
            end
            default: w_pp = '0;
        endcase
    end

    carry_lookahead_adder #(
        .N(W)
    ) u_cla (
        .i_a   (r_acc),
        .i_b   (w_pp),
        .i_cin (w_cin),
        .o_sum (w_sum),
        .o_cout(w_unused_cout)
    );

    assign w_shifted = (2*W+1)'($signed({w_sum, r_bx}) >>> 2);
    assign w_last    = (r_count == CW'(ITER - 1));
    assign w_accept  = in_valid && in_ready;
    assign w_ext_a   = is_signed & multiplicand[N-1];
    assign w_ext_b   = is_signed & multiplier[N-1];

    // Next state and the combinational input handshake
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    in_ready    = !reset;
                    w_state_nxt = in_valid ? RUN : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_acc       <= '0;
            r_bx        <= '0;
            r_count     <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == RUN);
            if (w_accept) begin
                r_a     <= {{2{w_ext_a}}, multiplicand};
                r_bx    <= {{2{w_ext_b}}, multiplier, 1'b0};
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_acc   <= w_shifted[2*W:W+1];
                r_bx    <= w_shifted[W:0];
                r_count <= r_count + CW'(1);
                // After the final shift the product sits in {acc, bx[W:1]}
                if (w_last) begin
                    r_product <= w_shifted[PW:1];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier at N=4, 8 and 16: directed
// boundary cases plus a randomized sweep checked against an integer model.
module tb_booth_radix4_multiplier;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  iv;
    logic [2:0]  sg;
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  bsy;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [31:0] p16;

    int errors = 0;
    int checks = 0;

    longint unsigned q0[$];
    longint unsigned q1[$];
    longint unsigned q2[$];
    logic [2:0]      stall;
    longint unsigned held[3];

    always #5 clock = ~clock;

    booth_radix4_multiplier #(.N(4)) u_n4 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .is_signed(sg[0]), .multiplicand(a4), .multiplier(b4),
        .out_valid(ov[0]), .out_ready(ordy[0]), .product(p4), .busy(bsy[0])
    );

    booth_radix4_multiplier #(.N(8)) u_n8 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .is_signed(sg[1]), .multiplicand(a8), .multiplier(b8),
        .out_valid(ov[1]), .out_ready(ordy[1]), .product(p8), .busy(bsy[1])
    );

    booth_radix4_multiplier #(.N(16)) u_n16 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .is_signed(sg[2]), .multiplicand(a16), .multiplier(b16),
        .out_valid(ov[2]), .out_ready(ordy[2]), .product(p16), .busy(bsy[2])
    );

    function automatic int nw(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 16);
    endfunction

    function automatic longint unsigned get_p(input int k);
        return (k == 0) ? 64'(p4) : ((k == 1) ? 64'(p8) : 64'(p16));
    endfunction

    function automatic longint unsigned get_a(input int k);
        return (k == 0) ? 64'(a4) : ((k == 1) ? 64'(a8) : 64'(a16));
    endfunction

    function automatic longint unsigned get_b(input int k);
        return (k == 0) ? 64'(b4) : ((k == 1) ? 64'(b8) : 64'(b16));
    endfunction

    // Reference: interpret operands as integers, multiply, keep 2N bits
    function automatic longint unsigned model(input int k, input bit s,
                                              input longint unsigned a,
                                              input longint unsigned b);
        int              n;
        longint          sa;
        longint          sb;
        longint unsigned m;
        n  = nw(k);
        sa = longint'(a);
        sb = longint'(b);
        m  = (64'd1 << (2 * n)) - 64'd1;
        if (s && a[n-1]) sa = sa - (64'sd1 <<< n);
        if (s && b[n-1]) sb = sb - (64'sd1 <<< n);
        return longint'(sa * sb) & m;
    endfunction

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : ((k == 1) ? q1.size() : q2.size());
    endfunction

    task automatic q_push(input int k, input longint unsigned v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic q_pop(input int k, output longint unsigned v);
        case (k)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic q_clear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chkv(input string nm, input longint unsigned act,
                        input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b at %0t", nm, act, req, $time);
        end
    endtask

    // Scoreboard: expectations enter on input handshake, leave on output handshake
    always @(negedge clock) begin
        longint unsigned v;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                q_clear(k);
                stall[k] = 1'b0;
                chk1("reset_out_valid", ov[k], 1'b0);
                chk1("reset_in_ready", ir[k], 1'b0);
                chk1("reset_busy", bsy[k], 1'b0);
            end else begin
                if (stall[k]) begin
                    chk1("hold_out_valid", ov[k], 1'b1);
                    chkv("hold_product", get_p(k), held[k]);
                end
                if (ov[k] && !ordy[k]) chk1("bp_in_ready", ir[k], 1'b0);
                if (ov[k] && ordy[k]) begin
                    if (q_size(k) == 0) begin
                        chk1("spurious_out_valid", 1'b1, 1'b0);
                    end else begin
                        q_pop(k, v);
                        chkv("product", get_p(k), v);
                    end
                end
                if (iv[k] && ir[k]) q_push(k, model(k, sg[k], get_a(k), get_b(k)));
                stall[k] = ov[k] && !ordy[k];
                held[k]  = get_p(k);
            end
        end
    end

    task automatic set_ops(input int k, input bit s, input longint unsigned a,
                           input longint unsigned b);
        sg[k] = s;
        case (k)
            0: begin a4 = 4'(a); b4 = 4'(b); end
            1: begin a8 = 8'(a); b8 = 8'(b); end
            default: begin a16 = 16'(a); b16 = 16'(b); end
        endcase
    endtask

    // Present operands until accepted; returns just after the accepting edge
    task automatic issue(input int k, input bit s, input longint unsigned a,
                         input longint unsigned b);
        bit acc;
        acc = 1'b0;
        set_ops(k, s, a, b);
        iv[k] = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clock);
            acc = ir[k];
            @(posedge clock);
        end
        #1;
        iv[k] = 1'b0;
        set_ops(k, ~s, 64'($urandom), 64'($urandom));
        if (!acc) chk1("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_valid(input int k, output int cyc);
        cyc = 0;
        while (!ov[k] && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        if (!ov[k]) chk1("out_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic directed(input int k, input bit s, input longint unsigned a,
                            input longint unsigned b, input longint unsigned req,
                            input string nm);
        int cyc;
        issue(k, s, a, b);
        wait_valid(k, cyc);
        chkv(nm, get_p(k), req);
        chkv("latency", 64'(cyc + 1), 64'(nw(k) / 2 + 2));
        @(posedge clock);
        #1;
    endtask

    function automatic longint unsigned pick(input int n);
        longint unsigned m;
        m = (64'd1 << n) - 64'd1;
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1 << (n - 1);
            2:       return m;
            3:       return 64'd1;
            default: return 64'($urandom) & m;
        endcase
    endfunction

    initial begin
        int cyc;
        bit s;
        reset = 1'b1;
        iv    = '0;
        sg    = '0;
        ordy  = '1;
        stall = '0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk1("init_in_ready", ir[k], 1'b0);
            chk1("init_out_valid", ov[k], 1'b0);
            chk1("init_busy", bsy[k], 1'b0);
            chkv("init_product", get_p(k), 64'd0);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk1("idle_in_ready", ir[1], 1'b1);

        // Boundary products
        directed(1, 1'b1, 64'h80, 64'h80, 64'h4000, "s8_min_squared");
        directed(1, 1'b0, 64'hFF, 64'hFF, 64'hFE01, "u8_max_squared");
        directed(1, 1'b1, 64'hFF, 64'h7F, 64'hFF81, "s8_neg1_x_127");
        directed(1, 1'b1, 64'h00, 64'hB3, 64'h0000, "s8_zero_x_neg77");
        directed(0, 1'b1, 64'h8, 64'h8, 64'h40, "s4_min_squared");
        directed(0, 1'b0, 64'hF, 64'hF, 64'hE1, "u4_max_squared");
        directed(2, 1'b1, 64'h8000, 64'h8000, 64'h4000_0000, "s16_min_squared");
        directed(2, 1'b0, 64'hFFFF, 64'hFFFF, 64'hFFFE_0001, "u16_max_squared");

        // Back-to-back: second op accepted in the DONE cycle of the first
        issue(1, 1'b1, 64'd3, 64'd5);
        set_ops(1, 1'b1, 64'hF9, 64'd9);
        iv[1] = 1'b1;
        wait_valid(1, cyc);
        chkv("b2b_first", get_p(1), 64'h000F);
        chk1("b2b_in_ready", ir[1], 1'b1);
        @(posedge clock);
        #1;
        iv[1] = 1'b0;
        chk1("b2b_busy", bsy[1], 1'b1);
        chk1("b2b_valid_low", ov[1], 1'b0);
        wait_valid(1, cyc);
        chkv("b2b_second", get_p(1), 64'hFFC1);
        chkv("b2b_latency", 64'(cyc + 1), 64'd6);
        @(posedge clock);
        #1;

        // Backpressure: result held, new op blocked until out_ready
        ordy[1] = 1'b0;
        issue(1, 1'b0, 64'd200, 64'd3);
        wait_valid(1, cyc);
        set_ops(1, 1'b1, 64'hFC, 64'd5);
        iv[1] = 1'b1;
        repeat (10) begin
            @(negedge clock);
            chk1("bp_out_valid", ov[1], 1'b1);
            chkv("bp_product", get_p(1), 64'h0258);
            chk1("bp_blocked", ir[1], 1'b0);
        end
        @(posedge clock);
        #1;
        ordy[1] = 1'b1;
        @(negedge clock);
        chk1("bp_release_ready", ir[1], 1'b1);
        @(posedge clock);
        #1;
        iv[1] = 1'b0;
        chk1("bp_accept_busy", bsy[1], 1'b1);
        wait_valid(1, cyc);
        chkv("bp_next", get_p(1), 64'hFFEC);
        @(posedge clock);
        #1;
        chk1("idle_valid_low", ov[1], 1'b0);
        chkv("idle_product_held", get_p(1), 64'hFFEC);

        // Reset during iteration 2 abandons the operation
        issue(1, 1'b1, 64'h55, 64'h33);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        #1;
        chk1("abort_out_valid", ov[1], 1'b0);
        chkv("abort_product", get_p(1), 64'd0);
        chk1("abort_busy", bsy[1], 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (12) begin
            @(negedge clock);
            chk1("abandoned_valid", ov[1], 1'b0);
        end
        directed(1, 1'b1, 64'd6, 64'hFA, 64'hFFDC, "s8_6_x_neg6");

        // Random sweep with random output backpressure
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                s = 1'($urandom);
                issue(k, s, pick(nw(k)), pick(nw(k)));
                for (int c = 0; c < 300; c++) begin
                    if (q_size(k) == 0 && !ov[k]) break;
                    @(posedge clock);
                    #1;
                    ordy[k] = ($urandom_range(0, 2) != 0);
                end
                ordy[k] = 1'b1;
                chk1("sweep_drain", (q_size(k) == 0) && !ov[k], 1'b1);
            end
        end

        repeat (4) @(posedge clock);
        for (int k = 0; k < 3; k++) chkv("final_queue_empty", 64'(q_size(k)), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
